// File: rtl/vram_pkg.sv
// Shared VRAM write-path definitions: address/data widths and the queued entry layout.
// Entries are packed with the address in the MSBs and the pixel data in the LSBs.
package vram_pkg;

    localparam int VRAM_ADDR_W = 17;
    localparam int VRAM_DATA_W = 8;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } vram_entry_t;

    localparam int VRAM_ENTRY_W = $bits(vram_entry_t);

endpackage

// File: rtl/vram_fifo_mem.sv
// Simple dual-port storage for the VRAM write FIFO: one write port and one
// enable-gated registered read port, written so it maps onto BRAM or LUTRAM.
module vram_fifo_mem #(
    parameter int AW = 5,
    parameter int W  = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  logic [W-1:0]  wr_entry,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_ptr,
    output logic [W-1:0]  rd_entry
);

    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] rd_entry_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Output register holds its value when no pop happens; reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_entry_q <= '0;
        end else if (rd_en) begin
            rd_entry_q <= mem[rd_ptr];
        end
    end

    assign rd_entry = rd_entry_q;

endmodule

// File: rtl/vram_write_fifo.sv
// CPU->VRAM write FIFO: absorbs CPU pixel writes between arbiter drain windows.
// Optional debug counters (ovf_cnt, hwm) are built when VRAM_FIFO_STATS_EN is defined.
module vram_write_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk100,
    input  logic                  reset,
    input  logic                  cpu_wr_req,
    input  logic [ADDR_W-1:0]     cpu_wr_addr,
    input  logic [DATA_W-1:0]     cpu_wr_data,
    output logic                  cpu_wr_ack,
    output logic                  cpu_stall,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
`ifdef VRAM_FIFO_STATS_EN
    output logic [15:0]           ovf_cnt,
    output logic [DEPTH_LOG2:0]   hwm,
`endif
    output logic [DEPTH_LOG2:0]   level
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] AF_LVL   = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - AF_MARGIN);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ack_q, ack_d;
    logic                  full, push, pop;
    logic [ENTRY_W-1:0]    rd_entry;

    // Flags come from the pre-edge level, so a full FIFO refuses a push even when popped.
    assign full        = (level_q == FULL_LVL);
    assign empty       = (level_q == '0);
    assign almost_full = (level_q >= AF_LVL);
    assign cpu_stall   = full;
    assign push        = cpu_wr_req & ~full;
    assign pop         = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        ack_d    = push;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
        end
    end

    vram_fifo_mem #(
        .AW (DEPTH_LOG2),
        .W  (ENTRY_W)
    ) u_mem (
        .clk      (clk100),
        .reset    (reset),
        .wr_en    (push),
        .wr_ptr   (wr_ptr_q),
        .wr_entry ({cpu_wr_addr, cpu_wr_data}),
        .rd_en    (pop),
        .rd_ptr   (rd_ptr_q),
        .rd_entry (rd_entry)
    );

    assign rd_addr    = rd_entry[ENTRY_W-1:DATA_W];
    assign rd_data    = rd_entry[DATA_W-1:0];
    assign cpu_wr_ack = ack_q;
    assign level      = level_q;

`ifdef VRAM_FIFO_STATS_EN
    logic [15:0]         ovf_cnt_q, ovf_cnt_d;
    logic [DEPTH_LOG2:0] hwm_q, hwm_d;

    // Overflow counts refused requests and saturates; hwm tracks the post-edge level.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (cpu_wr_req && full && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
        hwm_d = (level_d > hwm_q) ? level_d : hwm_q;
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            ovf_cnt_q <= '0;
            hwm_q     <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            hwm_q     <= hwm_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign hwm     = hwm_q;
`endif

endmodule

// File: tb/tb_vram_write_fifo.sv
// Self-checking bench for vram_write_fifo: vector table for the basic push/pop cases,
// then a scoreboard-driven model for fill, full/empty corners, random traffic and reset.
module tb_vram_write_fifo;

    logic        clk100;
    logic        reset;
    logic        cpu_wr_req;
    logic [16:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_ack;
    logic        cpu_stall;
    logic        almost_full;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data;
    logic        empty;
    logic [5:0]  level;
`ifdef VRAM_FIFO_STATS_EN
    logic [15:0] ovf_cnt;
    logic [5:0]  hwm;
`endif

    int errors = 0;
    int checks = 0;

    vram_write_fifo dut (
        .clk100      (clk100),
        .reset       (reset),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_wr_ack  (cpu_wr_ack),
        .cpu_stall   (cpu_stall),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .empty       (empty),
`ifdef VRAM_FIFO_STATS_EN
        .ovf_cnt     (ovf_cnt),
        .hwm         (hwm),
`endif
        .level       (level)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    typedef struct {
        logic        req;
        logic [16:0] addr;
        logic [7:0]  data;
        logic        rd;
        logic        exp_ack;
        logic [5:0]  exp_level;
        logic        exp_empty;
        logic [16:0] exp_rd_addr;
        logic [7:0]  exp_rd_data;
    } vec_t;

    // Model state
    logic [24:0] sb[$];
    int          m_level;
    logic        m_ack;
    logic [24:0] m_rd;
    int          m_ovf;
    int          m_hwm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_ack   = 1'b0;
        m_rd    = '0;
        m_ovf   = 0;
        m_hwm   = 0;
    endtask

    // One clock of traffic: check combinational flags, update model, step, check registered outputs.
    task automatic cycle(input logic req, input logic [16:0] a, input logic [7:0] d, input logic rd);
        logic do_push, do_pop;
        cpu_wr_req  = req;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        rd_en       = rd;
        #1;
        check("cpu_stall", 32'(cpu_stall), 32'(m_level == 32));
        check("empty_pre", 32'(empty), 32'(m_level == 0));
        check("almost_full", 32'(almost_full), 32'(m_level >= 30));
        do_push = req && (m_level < 32);
        do_pop  = rd && (m_level > 0);
        if (req && m_level == 32 && m_ovf < 16'hFFFF) m_ovf++;
        if (do_pop) m_rd = sb.pop_front();
        if (do_push) sb.push_back({a, d});
        if (do_push && !do_pop) m_level++;
        else if (do_pop && !do_push) m_level--;
        if (m_level > m_hwm) m_hwm = m_level;
        m_ack = do_push;
        @(posedge clk100);
        #1;
        check("cpu_wr_ack", 32'(cpu_wr_ack), 32'(m_ack));
        check("level", 32'(level), 32'(m_level));
        check("level_max", 32'(level <= 6'd32), 32'd1);
        check("rd_addr", 32'(rd_addr), 32'(m_rd[24:8]));
        check("rd_data", 32'(rd_data), 32'(m_rd[7:0]));
`ifdef VRAM_FIFO_STATS_EN
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        check("hwm", 32'(hwm), 32'(m_hwm));
`endif
    endtask

    initial begin
        vec_t vecs[5];
        logic [16:0] ra;
        logic [7:0]  rdat;

        vecs[0] = '{1'b1, 17'h00010, 8'hAB, 1'b0, 1'b1, 6'd1, 1'b0, 17'h00000, 8'h00};
        vecs[1] = '{1'b0, 17'h00000, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 17'h00010, 8'hAB};
        vecs[2] = '{1'b1, 17'h01234, 8'h77, 1'b1, 1'b1, 6'd1, 1'b0, 17'h00010, 8'hAB};
        vecs[3] = '{1'b0, 17'h00000, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 17'h01234, 8'h77};
        vecs[4] = '{1'b0, 17'h00000, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 17'h01234, 8'h77};

        reset       = 1'b1;
        cpu_wr_req  = 1'b0;
        cpu_wr_addr = '0;
        cpu_wr_data = '0;
        rd_en       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk100);
        #1;
        reset = 1'b0;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ack", 32'(cpu_wr_ack), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Basic push/pop vectors, including empty + push + pop (no fall-through)
        for (int i = 0; i < 5; i++) begin
            cpu_wr_req  = vecs[i].req;
            cpu_wr_addr = vecs[i].addr;
            cpu_wr_data = vecs[i].data;
            rd_en       = vecs[i].rd;
            @(posedge clk100);
            #1;
            check("vec_ack", 32'(cpu_wr_ack), 32'(vecs[i].exp_ack));
            check("vec_level", 32'(level), 32'(vecs[i].exp_level));
            check("vec_empty", 32'(empty), 32'(vecs[i].exp_empty));
            check("vec_rd_addr", 32'(rd_addr), 32'(vecs[i].exp_rd_addr));
            check("vec_rd_data", 32'(rd_data), 32'(vecs[i].exp_rd_data));
        end
        m_rd  = {17'h01234, 8'h77};
        m_hwm = 1;

        // Fill to 32 entries; almost_full from level 30
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 17'(i), 8'(i) ^ 8'h5A, 1'b0);
        end
        check("full_stall", 32'(cpu_stall), 32'd1);
        check("full_af", 32'(almost_full), 32'd1);

        // 33rd request refused
        cycle(1'b1, 17'h1FFFF, 8'hEE, 1'b0);
        check("ovf_noack", 32'(cpu_wr_ack), 32'd0);

        // Full + push + pop: pop proceeds (addr 0), push refused; retry accepted
        cycle(1'b1, 17'h1FFFF, 8'hEE, 1'b1);
        check("fullpp_addr", 32'(rd_addr), 32'h00000);
        check("fullpp_data", 32'(rd_data), 32'h5A);
        check("fullpp_level", 32'(level), 32'd31);
        check("fullpp_noack", 32'(cpu_wr_ack), 32'd0);
        cycle(1'b1, 17'h1FFFF, 8'hEE, 1'b0);
        check("retry_ack", 32'(cpu_wr_ack), 32'd1);
        check("retry_level", 32'(level), 32'd32);

        // Random interleaved traffic across pointer wrap
        for (int i = 0; i < 100; i++) begin
            ra   = 17'($urandom);
            rdat = 8'($urandom);
            cycle(1'($urandom_range(0, 1)), ra, rdat, 1'($urandom_range(0, 1)));
        end

        // Drain everything in order, then bring level to 17
        for (int i = 0; i < 40 && m_level > 0; i++) begin
            cycle(1'b0, 17'd0, 8'd0, 1'b1);
        end
        check("drained", 32'(empty), 32'd1);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 17'(i + 100), 8'(i * 3), 1'b0);
        end
        check("level17", 32'(level), 32'd17);

        // Reset mid-operation
        reset      = 1'b1;
        cpu_wr_req = 1'b0;
        rd_en      = 1'b0;
        @(posedge clk100);
        #1;
        reset = 1'b0;
        model_reset();
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check("mid_rst_ack", 32'(cpu_wr_ack), 32'd0);
`ifdef VRAM_FIFO_STATS_EN
        check("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
        check("mid_rst_hwm", 32'(hwm), 32'd0);
`endif

        // Fresh traffic after reset
        cycle(1'b1, 17'h0ABCD, 8'h3C, 1'b0);
        cycle(1'b0, 17'd0, 8'd0, 1'b1);
        check("post_rst_addr", 32'(rd_addr), 32'h0ABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
